// File: rtl/roi_scan_pkg.sv
// Shared types and sizing helpers for the ROI scan harness.
// Latency/backpressure: n/a (package only).
// Macro ROI_SCAN_PARITY_EN adds one trailing parity bit to the unload stream.
package roi_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_APPLY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_UNLOAD  = 3'd4
  } scan_state_e;

  localparam int DIN_N_DFLT      = 8;
  localparam int DOUT_N_DFLT     = 100;
  localparam int SETTLE_CYC_DFLT = 2;

  // Number of serial result bits emitted per scan.
  function automatic int unload_len(input int dout_n);
`ifdef ROI_SCAN_PARITY_EN
    return dout_n + 1;
`else
    return dout_n;
`endif
  endfunction

  localparam int UNLOAD_LEN = unload_len(DOUT_N_DFLT);

  // Counter width able to hold the largest of the three limits without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/roi_scan_harness_if.sv
// Host/ROI-facing bundle of the scan harness (stimulus in, result out, status).
// Latency/backpressure: n/a (wiring only); the serial result has no backpressure.
// master = host + ROI side, slave = harness. do_bit carries the serial result bit
// ("do" is a reserved word).
interface roi_scan_harness_if #(
  parameter int DIN_N  = 8,
  parameter int DOUT_N = 100
);
  logic              start;
  logic              di;
  logic              di_valid;
  logic [DIN_N-1:0]  din;
  logic [DOUT_N-1:0] dout;
  logic              do_bit;
  logic              do_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, di, di_valid, dout,
    input  din, do_bit, do_valid, busy, done
  );

  modport slave (
    input  start, di, di_valid, dout,
    output din, do_bit, do_valid, busy, done
  );
endinterface

// File: rtl/roi_scan_piso.sv
// Parallel-load / serial-out shift register, MSB first, zero fill.
// Latency: ser_out shows par_in MSB the cycle after load; one bit per shift.
// Backpressure: none; last flags the final bit (W-th) while it is on ser_out.
// Ports: load/shift controls, par_in vector, ser_out bit, last (count done).
module roi_scan_piso
  import roi_scan_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] par_in,
  output logic         ser_out,
  output logic         last
);
  localparam int CW = cnt_width(W, 0, 0);
  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  logic [W-1:0]  shr_q, shr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    shr_d = shr_q;
    cnt_d = cnt_q;
    if (load) begin
      shr_d = par_in;
      cnt_d = '0;
    end else if (shift) begin
      // Zero fill leaves ser_out low once the vector has drained.
      shr_d = shr_q << 1;
      if (cnt_q != LAST_IDX) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shr_q <= '0;
      cnt_q <= '0;
    end else begin
      shr_q <= shr_d;
      cnt_q <= cnt_d;
    end
  end

  assign ser_out = shr_q[W-1];
  assign last    = (cnt_q == LAST_IDX);

endmodule

// File: rtl/roi_scan_harness.sv
// Scan harness: serial load of DIN_N stimulus bits, parallel apply to the ROI,
// SETTLE_CYC wait, capture of DOUT_N results, serial unload MSB first.
// Latency: start -> first do_valid = DIN_N + SETTLE_CYC + 2 cycles without di stalls.
// Backpressure: di_valid low stalls LOAD; unload is free-running (no backpressure).
// Ports: clk, rst (async, active-high), bus (slave modport of roi_scan_harness_if).
// Macro ROI_SCAN_PARITY_EN: append even parity of the captured vector to the unload.
module roi_scan_harness
  import roi_scan_pkg::*;
#(
  parameter int DIN_N      = DIN_N_DFLT,
  parameter int DOUT_N     = DOUT_N_DFLT,
  parameter int SETTLE_CYC = SETTLE_CYC_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  roi_scan_harness_if.slave bus
);
  localparam int ULEN = unload_len(DOUT_N);
  localparam int CW   = cnt_width(DIN_N, DOUT_N, SETTLE_CYC);
  localparam logic [CW-1:0] LOAD_LAST   = CW'(DIN_N - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  scan_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIN_N-1:0] shr_q, shr_d;
  logic [DIN_N-1:0] din_q, din_d;
  logic             do_valid_q, do_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             piso_load;
  logic             piso_shift;
  logic             piso_last;
  logic             piso_out;
  logic [ULEN-1:0]  cap_vec;

`ifdef ROI_SCAN_PARITY_EN
  assign cap_vec = {bus.dout, ^bus.dout};
`else
  assign cap_vec = bus.dout;
`endif

  // The unload shadow is loaded on the CAPTURE edge and shifted once per UNLOAD cycle.
  assign piso_load  = (state_q == ST_CAPTURE);
  assign piso_shift = (state_q == ST_UNLOAD);

  roi_scan_piso #(.W(ULEN)) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load    (piso_load),
    .shift   (piso_shift),
    .par_in  (cap_vec),
    .ser_out (piso_out),
    .last    (piso_last)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shr_d      = shr_q;
    din_d      = din_q;
    do_valid_d = do_valid_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // done_q marks the cycle right after the last bit; a start there is dropped.
        if (bus.start && !done_q) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (bus.di_valid) begin
          shr_d = (shr_q << 1) | DIN_N'(bus.di);
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LOAD_LAST) begin
            din_d   = shr_d;
            cnt_d   = '0;
            state_d = (SETTLE_CYC == 0) ? ST_CAPTURE : ST_APPLY;
          end
        end
      end
      ST_APPLY: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CAPTURE: begin
        state_d    = ST_UNLOAD;
        do_valid_d = 1'b1;
      end
      ST_UNLOAD: begin
        if (piso_last) begin
          state_d    = ST_IDLE;
          do_valid_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shr_q      <= '0;
      din_q      <= '0;
      do_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shr_q      <= shr_d;
      din_q      <= din_d;
      do_valid_q <= do_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.din      = din_q;
  assign bus.do_bit   = piso_out;
  assign bus.do_valid = do_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_roi_scan_harness.sv
// Bench for roi_scan_harness: two instances (8/100/2 with a replicated-din ROI
// model, and 8/1/0 with dout tied high). Expected unload streams are queued when
// a scan is issued and consumed by an independent monitor.
module tb_roi_scan_harness;
  import roi_scan_pkg::*;

  localparam int DIN_N  = 8;
  localparam int DOUT_N = 100;
  localparam int SETTLE = 2;
  localparam int ULEN_B = unload_len(1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_q[$];
  int   bits_seen = 0;
  int   mon_act;
  logic              roi_fixed_en = 1'b0;
  logic [DOUT_N-1:0] roi_fixed = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  roi_scan_harness_if #(.DIN_N(DIN_N), .DOUT_N(DOUT_N)) ifa ();
  roi_scan_harness_if #(.DIN_N(DIN_N), .DOUT_N(1))      ifb ();

  // ROI stand-ins.
  assign ifa.dout = roi_fixed_en ? roi_fixed : {{12{ifa.din}}, 4'hA};
  assign ifb.dout = 1'b1;

  roi_scan_harness #(.DIN_N(DIN_N), .DOUT_N(DOUT_N), .SETTLE_CYC(SETTLE)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  roi_scan_harness #(.DIN_N(DIN_N), .DOUT_N(1), .SETTLE_CYC(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [DOUT_N-1:0] roi_model(input logic [DIN_N-1:0] pat);
    return roi_fixed_en ? roi_fixed : {{12{pat}}, 4'hA};
  endfunction

  // Expected stream: DOUT_N bits MSB first, optional parity, then a done marker (2).
  task automatic push_expect(input logic [DIN_N-1:0] pat);
    logic [DOUT_N-1:0] v;
    v = roi_model(pat);
    for (int i = DOUT_N - 1; i >= 0; i--) exp_q.push_back(v[i] ? 1 : 0);
`ifdef ROI_SCAN_PARITY_EN
    exp_q.push_back($countones(v) % 2);
`endif
    exp_q.push_back(2);
  endtask

  // Monitor: every do_valid or done cycle consumes one expected entry.
  always @(negedge clk) begin
    if (rst) begin
      bits_seen = 0;
    end else if (ifa.do_valid || ifa.done) begin
      mon_act = ifa.done ? (ifa.do_valid ? 3 : 2) : (ifa.do_bit ? 1 : 0);
      if (exp_q.size() == 0) chk("unexpected_output", mon_act, -1);
      else chk("unload_seq", mon_act, exp_q.pop_front());
      if (ifa.do_valid) bits_seen++;
      else bits_seen = 0;
    end else begin
      chk("do_zero_when_invalid", ifa.do_bit, 0);
    end
  end

  task automatic start_load(input logic [DIN_N-1:0] pat, input bit stall, input bit repulse,
                            output int t0, output int stalls);
    logic [DIN_N-1:0] din_before;
    int k;
    @(posedge clk); #1;
    ifa.start  = 1'b1;
    t0         = cyc;
    din_before = ifa.din;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    k = 0;
    stalls = 0;
    while (k < DIN_N) begin
      if (stall && ((cyc - t0) % 2 == 0)) begin
        ifa.di_valid = 1'b0;
        ifa.di       = 1'($urandom);
        stalls++;
      end else begin
        ifa.di_valid = 1'b1;
        ifa.di       = pat[DIN_N-1-k];
        k++;
      end
      ifa.start = repulse && (k == 4);
      @(negedge clk);
      chk("din_held_in_load", ifa.din, din_before);
      chk("busy_in_load", ifa.busy, 1);
      @(posedge clk); #1;
    end
    ifa.di_valid = 1'b0;
    ifa.start    = 1'b0;
    @(negedge clk);
    chk("din_loaded", ifa.din, pat);
  endtask

  task automatic scan_a(input logic [DIN_N-1:0] pat, input bit stall, input bit repulse);
    int t0, stalls, first, busy_low, idle_bad;
    bit got;
    push_expect(pat);
    start_load(pat, stall, repulse, t0, stalls);
    first = -1;
    busy_low = 0;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(posedge clk); #1;
      ifa.start = repulse && (c == 0 || c == 20 || $urandom_range(0, 3) == 0);
      @(negedge clk);
      if (ifa.do_valid && first < 0) first = cyc - t0;
      if (ifa.done) got = 1'b1;
      else if (!ifa.busy) busy_low++;
    end
    chk("done_seen", got, 1);
    chk("first_do_valid_latency", first, DIN_N + SETTLE + 2 + stalls);
    chk("busy_until_done", busy_low, 0);
    if (!got) exp_q.delete();
    // Driven now, so it is sampled on the edge closing the done cycle.
    ifa.start = repulse;
    idle_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      ifa.start = 1'b0;
      @(negedge clk);
      if (ifa.busy || ifa.do_valid || ifa.done) idle_bad++;
    end
    chk("no_restart_idle", idle_bad, 0);
    chk("expect_queue_drained", exp_q.size(), 0);
  endtask

  task automatic abort_test(input logic [DIN_N-1:0] pat);
    int t0, stalls, c;
    push_expect(pat);
    start_load(pat, 1'b0, 1'b0, t0, stalls);
    c = 0;
    while (bits_seen < 38 && c < 400) begin
      @(posedge clk);
      c++;
    end
    chk("abort_point_reached", bits_seen, 38);
    #2 rst = 1'b1;
    #1;
    chk("abort_do", ifa.do_bit, 0);
    chk("abort_do_valid", ifa.do_valid, 0);
    chk("abort_busy", ifa.busy, 0);
    chk("abort_done", ifa.done, 0);
    chk("abort_din", ifa.din, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic scan_b();
    logic [DIN_N-1:0] pat;
    int t0, nvalid, ndone, first, done_at;
    pat = 8'($urandom);
    @(posedge clk); #1;
    ifb.start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    for (int k = 0; k < DIN_N; k++) begin
      ifb.di_valid = 1'b1;
      ifb.di       = pat[DIN_N-1-k];
      @(posedge clk); #1;
    end
    ifb.di_valid = 1'b0;
    nvalid = 0; ndone = 0; first = -1; done_at = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 0) chk("b_din_loaded", ifb.din, pat);
      if (ifb.do_valid) begin
        nvalid++;
        if (first < 0) first = cyc - t0;
        chk("b_do_bit", ifb.do_bit, 1);
      end
      if (ifb.done) begin
        ndone++;
        if (done_at < 0) done_at = cyc - t0;
      end
      @(posedge clk); #1;
    end
    chk("b_first_valid_latency", first, DIN_N + 0 + 2);
    chk("b_valid_count", nvalid, ULEN_B);
    chk("b_done_cycle", done_at, DIN_N + 2 + ULEN_B);
    chk("b_done_count", ndone, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.start = 1'b0; ifa.di = 1'b0; ifa.di_valid = 1'b0;
    ifb.start = 1'b0; ifb.di = 1'b0; ifb.di_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_din", ifa.din, 0);
    chk("rst_do", ifa.do_bit, 0);
    chk("rst_do_valid", ifa.do_valid, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    @(posedge clk); #1 rst = 1'b0;

    scan_a(8'hA5, 1'b0, 1'b0);
    scan_a(8'h3C, 1'b1, 1'b0);
    scan_a(8'($urandom), 1'b0, 1'b1);
    abort_test(8'($urandom));
    scan_a(8'hA5, 1'b0, 1'b0);

    // Fixed ROI response with exactly 37 ones (odd parity).
    roi_fixed = '0;
    while ($countones(roi_fixed) < 37) roi_fixed[$urandom_range(0, DOUT_N - 1)] = 1'b1;
    roi_fixed_en = 1'b1;
    scan_a(8'($urandom), 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < DOUT_N; j++) roi_fixed[j] = 1'($urandom);
      scan_a(8'($urandom), (i == 1), (i == 2));
    end
    roi_fixed_en = 1'b0;

    scan_b();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
